// File: rtl/mul_job_sequencer.sv
// Job sequencer for the 4x4 shift-add multiplier core: operand FIFO,
// launch/capture FSM, result port and hung-core watchdog.
module mul_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] mul_in1,
  output logic [3:0] mul_in2,
  output logic       mul_go,
  output logic       mul_rst,
  input  logic       mul_done,
  input  logic [7:0] mul_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SETTLE,
    S_CAPTURE,
    S_ABORT,
    S_OUTPUT
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q;
  logic [3:0]    in1_q, in2_q;
  logic [7:0]    data_q;
  logic          go_q, pulse_q, rv_q, err_q;
  logic          push, pop, empty, full, launch;
  logic [7:0]    head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign push  = in_valid && !full;
  assign pop   = (state_q == S_LAUNCH);
  assign head  = mem_q[rd_q];

  assign launch = !empty &&
    ((state_q == S_IDLE) ||
     (state_q == S_OUTPUT && res_ready));

  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Core reset pulses on entry to CLEAR, CAPTURE and ABORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      pulse_q <= 1'b1;
      go_q    <= 1'b0;
      timer_q <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      rv_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      go_q    <= 1'b0;
      pulse_q <= 1'b0;
      if (launch) begin
        state_q        <= S_LAUNCH;
        go_q           <= 1'b1;
        {in1_q, in2_q} <= head;
      end
      unique case (state_q)
        S_CLEAR:  state_q <= S_IDLE;
        S_IDLE:   ;
        S_LAUNCH: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (mul_done) begin
            state_q <= S_SETTLE;
          end else if (timer_q == TW'(TIMEOUT)) begin
            state_q <= S_ABORT;
            pulse_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          state_q <= S_CAPTURE;
          pulse_q <= 1'b1;
        end
        S_CAPTURE: begin
          data_q  <= mul_out;
          err_q   <= 1'b0;
          rv_q    <= 1'b1;
          state_q <= S_OUTPUT;
        end
        S_ABORT: begin
          data_q  <= '0;
          err_q   <= 1'b1;
          rv_q    <= 1'b1;
          state_q <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (res_ready) begin
            rv_q <= 1'b0;
            if (empty) state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = !full;
  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;
  assign mul_go    = go_q;
  assign mul_rst   = rst || pulse_q;
  assign res_valid = rv_q;
  assign res_data  = data_q;
  assign res_err   = err_q;
  assign busy      = !empty ||
    !(state_q == S_IDLE || state_q == S_CLEAR);

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Bench for mul_job_sequencer: behavioural multiplier core,
// scoreboard queue of expected results, directed scenarios.
module tb_mul_job_sequencer;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] mul_in1, mul_in2;
  logic       mul_go, mul_rst;
  logic       mul_done = 1'b0;
  logic [7:0] mul_out = '0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;

  mul_job_sequencer #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_go(mul_go), .mul_rst(mul_rst),
    .mul_done(mul_done), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift-add core model: operands load one cycle after go,
  // done rises five cycles later, out follows done by one edge.
  logic       hang = 1'b0;
  logic       c_run = 1'b0;
  logic [2:0] c_cnt = '0;
  logic [3:0] c_a = '0, c_b = '0;
  always @(posedge clk) begin
    if (mul_rst) begin
      c_run    <= 1'b0;
      c_cnt    <= '0;
      mul_done <= 1'b0;
      mul_out  <= '0;
    end else begin
      if (mul_go && !c_run && !mul_done) begin
        c_run <= 1'b1;
        c_cnt <= '0;
      end else if (c_run) begin
        c_cnt <= c_cnt + 3'd1;
        if (c_cnt == 3'd0) begin
          c_a <= mul_in1;
          c_b <= mul_in2;
        end
        if (c_cnt == 3'd4) begin
          c_run    <= 1'b0;
          mul_done <= !hang;
        end
      end
      if (mul_done) mul_out <= {4'd0, c_a} * {4'd0, c_b};
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ngo = 0, nres = 0, npush = 0;
  int last_go = 0, last_mrst = 0, last_hs = 0;
  logic prev_go = 1'b0;
  logic [8:0] e;
  logic [8:0] exp_q[$];
  int hs_q[$];

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_go) begin
        ngo++;
        last_go = cyc;
        chk("go_pulse", int'(prev_go), 0);
      end
      if (mul_rst) last_mrst = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", int'(res_data), int'(e[7:0]));
          chk("res_err", int'(res_err), int'(e[8]));
        end
        nres++;
        last_hs = cyc;
        hs_q.push_back(cyc);
      end
    end
    prev_go = mul_go;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [3:0] a, input logic [3:0] b,
                          input logic err);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_acc", int'(in_ready), 1);
    exp_q.push_back({err, err ? 8'd0 : 8'({4'd0, a} * {4'd0, b})});
    npush++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(res_valid), 1);
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (nres < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("res_count", nres, target);
    step();
  endtask

  task automatic test_full();
    int np0 = npush;
    int r0 = nres;
    res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          push_job(4'(i + 2), 4'(i + 3), 1'b0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (in_ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("full_ready", int'(in_ready), 0);
        chk("full_queued", npush - np0, 5);
        repeat (10) @(negedge clk);
        chk("full_hold_rv", int'(res_valid), 1);
        chk("full_hold_rdy", int'(in_ready), 0);
        step();
        res_ready = 1'b1;
      end
    join
    wait_res(r0 + 6);
    chk("full_drained", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got 0 want 1");
    $fatal(1, "bench stuck");
  end

  initial begin
    int d, g0, r0, d0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_go", int'(mul_go), 0);
    chk("rst_rv", int'(res_valid), 0);
    chk("rst_data", int'(res_data), 0);
    chk("rst_err", int'(res_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mrst", int'(mul_rst), 1);
    chk("rst_in1", int'(mul_in1), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("clr_mrst", int'(mul_rst), 1);
    @(negedge clk);
    chk("idle_mrst", int'(mul_rst), 0);
    chk("idle_busy", int'(busy), 0);
    step();

    // single job
    push_job(4'd13, 4'd11, 1'b0);
    wait_rv("one_rv");
    chk("one_lat", cyc - last_go, 9);
    chk("one_mrst", last_mrst - last_go, 8);
    chk("one_data", int'(res_data), 143);
    wait_res(1);

    // back-to-back
    hs_q.delete();
    r0 = nres;
    push_job(4'd15, 4'd15, 1'b0);
    chk("b2b_rdy0", int'(in_ready), 1);
    push_job(4'd0, 4'd9, 1'b0);
    chk("b2b_rdy1", int'(in_ready), 1);
    push_job(4'd1, 4'd1, 1'b0);
    chk("b2b_rdy2", int'(in_ready), 1);
    push_job(4'd7, 4'd8, 1'b0);
    chk("b2b_rdy3", int'(in_ready), 1);
    wait_res(r0 + 4);
    for (int i = 0; i < 3 && i + 1 < hs_q.size(); i++)
      chk("b2b_period", hs_q[i + 1] - hs_q[i], 10);

    test_full();

    // result backpressure
    r0 = nres;
    res_ready = 1'b0;
    push_job(4'd12, 4'd12, 1'b0);
    push_job(4'd3, 4'd9, 1'b0);
    wait_rv("bp_rv");
    d0 = int'(res_data);
    g0 = ngo;
    repeat (20) @(negedge clk);
    chk("bp_stable", int'(res_data), d0);
    chk("bp_val", d0, 144);
    chk("bp_nogo", ngo, g0);
    chk("bp_busy", int'(busy), 1);
    chk("bp_valid", int'(res_valid), 1);
    step();
    res_ready = 1'b1;
    d = 0;
    while (ngo == g0 && d < 50) begin
      @(negedge clk);
      d++;
    end
    chk("bp_launch", last_go - last_hs, 1);
    wait_res(r0 + 2);

    // timeout on hung core
    r0 = nres;
    hang = 1'b1;
    push_job(4'd3, 4'd5, 1'b1);
    push_job(4'd6, 4'd7, 1'b0);
    wait_rv("to_rv");
    hang = 1'b0;
    d = cyc - last_go;
    chk("to_lat_min", int'(d >= TIMEOUT + 2), 1);
    chk("to_lat_max", int'(d <= TIMEOUT + 3), 1);
    chk("to_err", int'(res_err), 1);
    wait_res(r0 + 2);

    // async reset mid-job
    g0 = ngo;
    push_job(4'd2, 4'd3, 1'b0);
    push_job(4'd4, 4'd5, 1'b0);
    d = 0;
    while (ngo == g0 && d < 50) begin
      @(negedge clk);
      d++;
    end
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mr_rv", int'(res_valid), 0);
    chk("mr_go", int'(mul_go), 0);
    chk("mr_data", int'(res_data), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_rdy", int'(in_ready), 1);
    chk("mr_mrst", int'(mul_rst), 1);
    chk("mr_in1", int'(mul_in1), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_clr", int'(mul_rst), 1);
    @(negedge clk);
    chk("mr_idle", int'(mul_rst), 0);
    chk("mr_idle_busy", int'(busy), 0);
    step();
    r0 = nres;
    push_job(4'd9, 4'd7, 1'b0);
    wait_rv("mr_rv2");
    chk("mr_res", int'(res_data), 63);
    wait_res(r0 + 1);
    chk("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_job_sequencer.md
Name: mul_job_sequencer

Overview:
- Front-end and back-end stage for the 4x4 shift-add multiplier core.
- Upstream, it accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It launches one multiplication at a time by driving the core's in1/in2/go, then captures the product after the core's done.
- It clears the core between jobs with a reset pulse, because the core holds done until it is reset.
- Downstream, it presents each product on a valid/ready result port; a timeout watchdog recovers from a hung core.

Parameters:
- DEPTH, 4, operand FIFO entries; power of 2, minimum 2.
- TIMEOUT, 15, maximum cycles in WAIT before abort; must be at least 8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  4  multiplicand.
- in_b  in  4  multiplier.
- mul_in1  out  4  to core in1.
- mul_in2  out  4  to core in2.
- mul_go  out  1  to core go.
- mul_rst  out  1  to core rst (core reset is synchronous).
- mul_done  in  1  from core done.
- mul_out  in  8  from core out.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  8  product.
- res_err  out  1  qualifies res_valid; 1 = timeout, res_data = 0.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset values:
  - in_ready=1; mul_go=0; res_valid=0; res_data=0; res_err=0; busy=0.
  - mul_in1/mul_in2=0; FIFO empty; FSM in CLEAR.
  - mul_rst = rst OR internal pulse, so the core is held in reset while rst is high.
- FIFO:
  - Push when in_valid & in_ready; pop on the LAUNCH to WAIT transition.
  - Push and pop in the same cycle are both allowed; a push while full is impossible because in_ready=0.
  - Pointers wrap modulo DEPTH; an extra count bit distinguishes full from empty.
- Operand hold: mul_in1/mul_in2 are registered from the FIFO head on entry to LAUNCH. They stay stable until the next LAUNCH, because the core loads operands one cycle after sampling go.
- FSM states and transitions:
  - CLEAR: mul_rst=1 for exactly one cycle; then IDLE.
  - IDLE: if the FIFO is non-empty, go to LAUNCH.
  - LAUNCH: mul_go=1 for one cycle; pop; then WAIT. The timer is cleared.
  - WAIT: the timer increments each cycle. If mul_done=1, go to SETTLE. Else if timer==TIMEOUT, go to ABORT.
  - SETTLE: one cycle, because the core's out register loads on the edge after done rises. Then CAPTURE.
  - CAPTURE: res_data <= mul_out; res_err <= 0; mul_rst=1 for this cycle; then OUTPUT.
  - ABORT: res_data <= 0; res_err <= 1; mul_rst=1; then OUTPUT.
  - OUTPUT: res_valid=1, with res_data and res_err held stable. When res_ready=1, res_valid drops on the next edge; the next state is LAUNCH if the FIFO is non-empty, else IDLE.
- Latency with the standard core:
  - mul_go high in cycle 0; mul_done rises in cycle 6; SETTLE in cycle 7; CAPTURE in cycle 8.
  - res_valid rises in cycle 9.
  - With res_ready tied high, the job-to-job period is 10 cycles.
- Backpressure: while res_ready=0, OUTPUT holds indefinitely and no new job launches; the FIFO keeps accepting until full.
- mul_done outside WAIT/SETTLE is ignored.
- Asynchronous rst mid-job: all state clears immediately and FIFO contents are discarded. After rst deasserts, the FSM passes through CLEAR (one more core reset cycle) before IDLE.
- Arithmetic: none internally. res_data is the core's 8-bit product, so the maximum is 15*15=225.

Test Plan:
- Single job: push a=13, b=11 into an idle block -> mul_go is a one-cycle pulse; res_valid rises 9 cycles after mul_go with res_data=143 and res_err=0; mul_rst pulses in the CAPTURE cycle.
- Back-to-back jobs: push (15,15), (0,9), (1,1), (7,8) on consecutive cycles with res_ready=1 -> results 225, 0, 1, 56 in order, each 10 cycles apart. in_ready stays 1 for DEPTH=4, because the first pop occurs before the fourth push.
- FIFO full: hold res_ready=0 and push 6 pairs -> in_ready drops once 4 entries are queued while the first result waits. Deassert then: all results are delivered in order and none are lost or duplicated.
- Result backpressure: keep res_ready=0 for 20 cycles after res_valid -> res_data is stable, no mul_go is issued, and busy=1. Assert res_ready -> the next launch follows on the next cycle.
- Timeout: a stub core never asserts done -> ABORT after TIMEOUT cycles in WAIT; res_valid=1 with res_err=1 and res_data=0; the next queued job then completes normally.
- Reset mid-job: assert rst during WAIT -> all outputs immediately take their reset values and mul_rst=1. After release, one CLEAR cycle, then IDLE with busy=0; a new job computes correctly.
